// File: rtl/vga_timing_if.sv
// Raster bus between the VGA timing generator and the renderer: coordinates,
// pixel strobe, frame tick, the renderer's colour back in, and the VGA pin set.
interface vga_timing_if;
    logic [10:0] x;
    logic [10:0] y;
    logic        pix_tick;
    logic        frame_start;
    logic [7:0]  rgb_in;
    logic [7:0]  rgb_out;
    logic        hsync_n;
    logic        vsync_n;
    logic        video_on;

    modport master (
        output x, y, pix_tick, frame_start, rgb_out, hsync_n, vsync_n, video_on,
        input  rgb_in
    );

    modport slave (
        input  x, y, pix_tick, frame_start, rgb_out, hsync_n, vsync_n, video_on,
        output rgb_in
    );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing: pixel-enable divider, h/v counters, sync/blank flags delayed
// to match the renderer pipeline, and a blanked colour output register.
module vga_timing #(
    parameter int CLK_DIV  = 4,
    parameter int PIPE_DLY = 2,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic         clk,
    input  logic         reset,
    vga_timing_if.master vga
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_VIS);
    localparam logic [10:0] V_VIS_END  = 11'(V_VIS);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VIS + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VIS + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_VIS + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_reg;
    logic [10:0]      h_reg;
    logic [10:0]      v_reg;
    logic             frame_start_reg;
    logic [7:0]       rgb_out_reg;
    logic             pix_tick;
    logic             line_end;
    logic             frame_end;
    logic             hs_raw;
    logic             vs_raw;
    logic             vis_raw;
    logic             gate_vis;

    // Each stage holds {hs, vs, vis}; index 0 is closest to the counters.
    logic [PIPE_DLY-1:0][2:0] stage_reg;
    logic [PIPE_DLY-1:0][2:0] stage_next;

    // Gated by reset so the strobe is low while held, even when CLK_DIV==1.
    assign pix_tick  = reset && (div_reg == DIV_LAST);
    assign line_end  = (h_reg == H_LAST);
    assign frame_end = line_end && (v_reg == V_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_reg <= '0;
        end else if (div_reg == DIV_LAST) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_reg           <= '0;
            v_reg           <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= pix_tick && frame_end;
            if (pix_tick) begin
                if (line_end) begin
                    h_reg <= '0;
                    v_reg <= (v_reg == V_LAST) ? 11'd0 : v_reg + 11'd1;
                end else begin
                    h_reg <= h_reg + 11'd1;
                end
            end
        end
    end

    assign vis_raw = (h_reg < H_VIS_END) && (v_reg < V_VIS_END);
    assign hs_raw  = !((h_reg >= H_SYNC_BEG) && (h_reg < H_SYNC_END));
    assign vs_raw  = !((v_reg >= V_SYNC_BEG) && (v_reg < V_SYNC_END));

    assign stage_next[0] = {hs_raw, vs_raw, vis_raw};

    genvar gi;
    generate
        for (gi = 1; gi < PIPE_DLY; gi++) begin : g_stage
            assign stage_next[gi] = stage_reg[gi-1];
        end

        // The colour register is itself one stage, so it gates with the flag one stage early.
        if (PIPE_DLY == 1) begin : g_gate_raw
            assign gate_vis = vis_raw;
        end else begin : g_gate_pipe
            assign gate_vis = stage_reg[PIPE_DLY-2][0];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_reg   <= {PIPE_DLY{3'b110}};
            rgb_out_reg <= 8'h00;
        end else begin
            stage_reg   <= stage_next;
            rgb_out_reg <= gate_vis ? vga.rgb_in : 8'h00;
        end
    end

    assign vga.x           = h_reg;
    assign vga.y           = v_reg;
    assign vga.pix_tick    = pix_tick;
    assign vga.frame_start = frame_start_reg;
    assign vga.rgb_out     = rgb_out_reg;
    assign vga.hsync_n     = stage_reg[PIPE_DLY-1][2];
    assign vga.vsync_n     = stage_reg[PIPE_DLY-1][1];
    assign vga.video_on    = stage_reg[PIPE_DLY-1][0];
endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: two reduced-raster instances (CLK_DIV 4 and 1) checked cycle by
// cycle from a scoreboard queue, plus an asynchronous mid-frame reset.
module tb_vga_timing;
    // Reduced raster: H 8+2+3+3 = 16, V 4+1+2+1 = 8
    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = 16, VT = 8;
    localparam int DA = 4, DB = 1, P = 2;

    // Hand-derived per-position flags (bit index = h or v)
    logic [15:0] hs_pat  = 16'hE3FF;   // low at h = 10,11,12
    logic [15:0] vis_h   = 16'h00FF;   // h = 0..7
    logic [7:0]  vs_pat  = 8'h9F;      // low at v = 5,6
    logic [7:0]  vis_v   = 8'h0F;      // v = 0..3

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        tick;
        logic        fs;
        logic [7:0]  rgb;
        logic        hs;
        logic        vs;
        logic        vis;
    } obs_t;

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    int    checks = 0;
    int    errors = 0;
    int    t = 0;
    string phase = "reset";

    obs_t exp_a[$];
    obs_t exp_b[$];
    int   exp_t[$];

    always #5 clk = ~clk;

    vga_timing_if bus_a();
    vga_timing_if bus_b();

    vga_timing #(
        .CLK_DIV(DA), .PIPE_DLY(P),
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut_a (
        .clk(clk), .reset(reset), .vga(bus_a)
    );

    vga_timing #(
        .CLK_DIV(DB), .PIPE_DLY(P),
        .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut_b (
        .clk(clk), .reset(reset), .vga(bus_b)
    );

    // Renderer stand-ins: A returns a one-clk registered ramp of x, B a constant white.
    always @(posedge clk) bus_a.rgb_in <= bus_a.x[7:0];
    assign bus_b.rgb_in = 8'hFF;

    // Expected outputs in cycle tc after reset release; tc < 0 means reset is held.
    function automatic obs_t model(int tc, int d, bit ramp);
        obs_t o;
        int   p, s, ps, h, v;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        if (tc < 0) return o;
        p    = tc / d;
        o.x  = 11'(p % HT);
        o.y  = 11'((p / HT) % VT);
        o.tick = ((tc % d) == d - 1);
        o.fs   = (tc > 0) && ((tc % (d * HT * VT)) == 0);
        s = tc - P;
        if (s >= 0) begin
            ps    = s / d;
            h     = ps % HT;
            v     = (ps / HT) % VT;
            o.hs  = hs_pat[h];
            o.vs  = vs_pat[v];
            o.vis = vis_h[h] & vis_v[v];
            o.rgb = o.vis ? (ramp ? 8'(h) : 8'hFF) : 8'h00;
        end
        return o;
    endfunction

    function automatic obs_t sample_a();
        obs_t o;
        o = {bus_a.x, bus_a.y, bus_a.pix_tick, bus_a.frame_start, bus_a.rgb_out,
             bus_a.hsync_n, bus_a.vsync_n, bus_a.video_on};
        return o;
    endfunction

    function automatic obs_t sample_b();
        obs_t o;
        o = {bus_b.x, bus_b.y, bus_b.pix_tick, bus_b.frame_start, bus_b.rgb_out,
             bus_b.hsync_n, bus_b.vsync_n, bus_b.video_on};
        return o;
    endfunction

    task automatic check_obs(string name, int tc, obs_t got, obs_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s/%s t=%0d got x=%0d y=%0d tick=%0b fs=%0b rgb=%02h hs=%0b vs=%0b vis=%0b want x=%0d y=%0d tick=%0b fs=%0b rgb=%02h hs=%0b vs=%0b vis=%0b",
                     phase, name, tc, got.x, got.y, got.tick, got.fs, got.rgb, got.hs, got.vs, got.vis,
                     want.x, want.y, want.tick, want.fs, want.rgb, want.hs, want.vs, want.vis);
        end
    endtask

    task automatic check_val(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push_cycle(int tc);
        exp_a.push_back(model(tc, DA, 1'b1));
        exp_b.push_back(model(tc, DB, 1'b0));
        exp_t.push_back(tc);
    endtask

    task automatic hold_reset(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            push_cycle(-1);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        t = 0;
        push_cycle(0);
        t = 1;
    endtask

    task automatic run(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            push_cycle(t);
            t++;
        end
    endtask

    // Monitor: compares every presented cycle against the queued expectation.
    initial begin
        obs_t ea, eb;
        int   tc;
        forever begin
            @(negedge clk);
            if (exp_a.size() > 0) begin
                ea = exp_a.pop_front();
                eb = exp_b.pop_front();
                tc = exp_t.pop_front();
                check_obs("dut_a", tc, sample_a(), ea);
                check_obs("dut_b", tc, sample_b(), eb);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        phase = "reset";
        hold_reset(4);
        $display("phase reset: checks=%0d errors=%0d", checks, errors);

        phase = "frames";
        release_reset();
        run(1100);
        $display("phase frames: checks=%0d errors=%0d", checks, errors);

        // Second release, stop A at x=5 y=2 (cycle 148), then pull reset between edges.
        phase = "midframe";
        @(posedge clk);
        #2;
        reset = 1'b0;
        hold_reset(2);
        release_reset();
        run(148);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_val("async_rst a.x", int'(bus_a.x), 0);
        check_val("async_rst a.y", int'(bus_a.y), 0);
        check_val("async_rst a.rgb_out", int'(bus_a.rgb_out), 0);
        check_val("async_rst a.hsync_n", int'(bus_a.hsync_n), 1);
        check_val("async_rst a.vsync_n", int'(bus_a.vsync_n), 1);
        check_val("async_rst b.x", int'(bus_b.x), 0);
        check_val("async_rst b.y", int'(bus_b.y), 0);
        check_val("async_rst b.pix_tick", int'(bus_b.pix_tick), 0);
        check_val("async_rst b.video_on", int'(bus_b.video_on), 0);
        push_cycle(-1);
        hold_reset(3);
        $display("phase midframe: checks=%0d errors=%0d", checks, errors);

        phase = "restart";
        release_reset();
        run(600);
        @(negedge clk);
        #1;
        check_val("scoreboard drained", exp_a.size(), 0);
        $display("phase restart: checks=%0d errors=%0d", checks, errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
